vec_lane_sequencer: RTL and testbench
=====================================

# vec_lane_sequencer

Parametrised successor to the vector fork stage in the vector datapath. Captures two V-element register-file read vectors plus a scalar on a start handshake, then streams them as L-lane operand chunks (A, B) to the lane ALUs, one chunk per accepted cycle. Supports vector-vector, vector-scalar and scalar-vector operand modes, downstream back-pressure, and a partial final chunk when V is not a multiple of L.

## Interface
- N, 32, element width in bits
- V, 20, elements per vector (≥1)
- L, 4, lanes per output chunk (1 ≤ L ≤ V)
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- start_i  in  1  request to begin an operation
- OpType  in  2  00 nop, 01 vector-vector, 10 vector-scalar, 11 scalar-vector
- RD1_VEC_i  in  [V-1:0][N-1:0]  source vector 1
- RD2_VEC_i  in  [V-1:0][N-1:0]  source vector 2
- Scalar_i  in  N  scalar operand
- stall_i  in  1  downstream cannot accept the current chunk
- ready_o  out  1  idle, start_i is accepted this cycle
- valid_o  out  1  Vec_A_o/Vec_B_o hold a valid chunk
- Vec_A_o  out  [L-1:0][N-1:0]  A-operand lanes
- Vec_B_o  out  [L-1:0][N-1:0]  B-operand lanes
- chunk_idx_o  out  $clog2(C) (min 1)  index of current chunk, C = ceil(V/L)
- last_o  out  1  current chunk is chunk C-1
- done_o  out  1  one-cycle pulse, operation complete

## Operation
- States: IDLE, STREAM, DONE. ready_o = (state == IDLE).
- IDLE: start_i=1 at edge → latch RD1, RD2, Scalar_i, OpType; chunk index = 0; go to STREAM (OpType 01/10/11) or DONE (OpType 00).
- Inputs after the accept edge are ignored; the latched copy is used.
- Chunk k, lane j, element e = k·L + j:
  - 01: A = RD1[e], B = RD2[e]
  - 10: A = RD1[e], B = Scalar
  - 11: A = Scalar, B = RD2[e]
  - e ≥ V: A = B = 0 (pad lanes, including the scalar side).
- STREAM: valid_o=1. Edge with stall_i=0: if last chunk → DONE, else index+1. Edge with stall_i=1: all outputs hold.
- DONE: done_o=1, valid_o=0, ready_o=0, start_i ignored; next edge → IDLE.
- start_i while not in IDLE: ignored, not queued.

## Timing
- Reset (RST=1 at edge): state IDLE, valid_o=0, done_o=0, last_o=0, chunk_idx_o=0, Vec_A_o=Vec_B_o=0, ready_o=1 from the cycle after. start_i is ignored while RST=1.
- RST mid-STREAM or in DONE: abort to IDLE, no done_o.
- Accept at edge t → first chunk valid from t+1. Unstalled, chunk k is valid in cycle t+1+k; done_o is in cycle t+1+C; ready_o is in cycle t+2+C.
- OpType 00: done_o in t+1, ready_o in t+2, valid_o never asserted.
- Outputs are registered/state-derived. stall_i affects only the next edge (no combinational path to ready_o or valid_o).
- C=1 (L=V): last_o=1 with the first chunk.

## Configuration
- VEC_SEQ_LANE_MASK_EN defined: extra output port mask_o [L-1:0], where bit j = (k·L + j < V) while valid_o=1, and 0 otherwise. Reset value 0.
- VEC_SEQ_LANE_MASK_EN not defined: mask_o port is absent. Pad lanes are still driven to zero. All other behaviour is identical.

## Structure
- Package vec_seq_pkg holds:
  - op_t enum (OP_NOP, OP_VV, OP_VS, OP_SV) for OpType
  - seq_state_t enum (IDLE, STREAM, DONE)
  - constant function ceil_div for C
- Sub-module vec_chunk_mux is combinational. Given latched vectors, scalar, op and chunk index, it produces the L-lane A/B chunk and the lane mask. The sequencer top holds the FSM, capture registers and output registers.

## Test plan
- N=32, V=20, L=4, OpType=01, RD1[i]=i, RD2[i]=2i, no stall → 5 chunks in consecutive cycles. Chunk 2: A={8,9,10,11}, B={16,18,20,22}. last_o with chunk 4. done_o one cycle later, then ready_o.
- Same data, OpType=10, Scalar=3 → B lanes all 3 in every chunk; A as above.
- V=18, L=4, OpType=11, Scalar=7 → chunk 4: A={7,7,0,0}, B={32,34,0,0}. mask_o=4'b0011 when the macro is defined.
- stall_i=1 for 3 cycles during chunk 1 → chunk 1 held unchanged for 4 cycles, done_o delayed by 3. Change RD1_VEC_i after accept → output unaffected.
- RST pulse during chunk 2 → next cycle valid_o=0, ready_o=1, no done_o. A new start then runs a full sequence from chunk 0.
- OpType=00 start → done_o next cycle, no valid_o. start_i held high in DONE is ignored. start_i is accepted again one cycle later.

Source files
------------

// File: rtl/vec_seq_pkg.sv
// Shared types and sizing helpers for the vector lane sequencer.
// The sequencer and chunk mux use these (VEC_SEQ_LANE_MASK_EN adds the lane mask port).
package vec_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_VV  = 2'b01,
        OP_VS  = 2'b10,
        OP_SV  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } seq_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Index width never drops below one bit, even for a single-chunk vector.
    function automatic int idx_width(input int c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

endpackage

// File: rtl/vec_chunk_mux.sv
// Combinational selection of one L-lane A/B operand chunk from the latched vectors.
// The lane mask output exists only when VEC_SEQ_LANE_MASK_EN is defined.
module vec_chunk_mux import vec_seq_pkg::*; #(
    parameter int N  = 32,
    parameter int V  = 20,
    parameter int L  = 4,
    parameter int IW = 3
) (
    input  logic [V-1:0][N-1:0] rd1,
    input  logic [V-1:0][N-1:0] rd2,
    input  logic [N-1:0]        scalar,
    input  op_t                 op,
    input  logic [IW-1:0]       chunk_idx,
    output logic [L-1:0][N-1:0] vec_a,
    output logic [L-1:0][N-1:0] vec_b
`ifdef VEC_SEQ_LANE_MASK_EN
    ,
    output logic [L-1:0]        mask
`endif
);

    localparam int SW = (V > 1) ? $clog2(V) : 1;

    // Lanes whose element index runs past V stay zero on both operand sides.
    always_comb begin
        int e;
        logic [SW-1:0] el;
        e     = 0;
        el    = '0;
        vec_a = '0;
        vec_b = '0;
`ifdef VEC_SEQ_LANE_MASK_EN
        mask  = '0;
`endif
        for (int j = 0; j < L; j++) begin
            e = int'(chunk_idx) * L + j;
            if (e < V) begin
                el = SW'(e);
`ifdef VEC_SEQ_LANE_MASK_EN
                mask[j] = 1'b1;
`endif
                case (op)
                    OP_VS: begin
                        vec_a[j] = rd1[el];
                        vec_b[j] = scalar;
                    end
                    OP_SV: begin
                        vec_a[j] = scalar;
                        vec_b[j] = rd2[el];
                    end
                    default: begin
                        vec_a[j] = rd1[el];
                        vec_b[j] = rd2[el];
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Captures two vectors plus a scalar on start and streams them as L-lane operand chunks.
// Define VEC_SEQ_LANE_MASK_EN to add the mask_o port marking real (non-pad) lanes.
module vec_lane_sequencer import vec_seq_pkg::*; #(
    parameter  int N  = 32,
    parameter  int V  = 20,
    parameter  int L  = 4,
    localparam int C  = ceil_div(V, L),
    localparam int IW = idx_width(C)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start_i,
    input  logic [1:0]          OpType,
    input  logic [V-1:0][N-1:0] RD1_VEC_i,
    input  logic [V-1:0][N-1:0] RD2_VEC_i,
    input  logic [N-1:0]        Scalar_i,
    input  logic                stall_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [L-1:0][N-1:0] Vec_A_o,
    output logic [L-1:0][N-1:0] Vec_B_o,
    output logic [IW-1:0]       chunk_idx_o,
    output logic                last_o,
    output logic                done_o
`ifdef VEC_SEQ_LANE_MASK_EN
    ,
    output logic [L-1:0]        mask_o
`endif
);

    localparam logic [IW-1:0] LAST_IDX = IW'(C - 1);

    seq_state_t          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                capture;
    logic [V-1:0][N-1:0] rd1_q, rd2_q;
    logic [N-1:0]        scalar_q;
    op_t                 op_q;
    logic [L-1:0][N-1:0] chunk_a, chunk_b;
`ifdef VEC_SEQ_LANE_MASK_EN
    logic [L-1:0]        chunk_mask;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Operands are frozen at accept so later input changes cannot disturb the stream.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd1_q    <= '0;
            rd2_q    <= '0;
            scalar_q <= '0;
            op_q     <= OP_NOP;
        end else if (capture) begin
            rd1_q    <= RD1_VEC_i;
            rd2_q    <= RD2_VEC_i;
            scalar_q <= Scalar_i;
            op_q     <= op_t'(OpType);
        end
    end

    vec_chunk_mux #(
        .N  (N),
        .V  (V),
        .L  (L),
        .IW (IW)
    ) u_chunk_mux (
        .rd1       (rd1_q),
        .rd2       (rd2_q),
        .scalar    (scalar_q),
        .op        (op_q),
        .chunk_idx (idx_q),
        .vec_a     (chunk_a),
        .vec_b     (chunk_b)
`ifdef VEC_SEQ_LANE_MASK_EN
        ,
        .mask      (chunk_mask)
`endif
    );

    // All outputs derive from registered state, so stall_i only matters at the next edge.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        capture     = 1'b0;
        ready_o     = (state_q == IDLE);
        valid_o     = (state_q == STREAM);
        done_o      = (state_q == DONE);
        last_o      = (state_q == STREAM) && (idx_q == LAST_IDX);
        chunk_idx_o = idx_q;
        Vec_A_o     = (state_q == STREAM) ? chunk_a : '0;
        Vec_B_o     = (state_q == STREAM) ? chunk_b : '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = (op_t'(OpType) == OP_NOP) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (!stall_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

`ifdef VEC_SEQ_LANE_MASK_EN
    assign mask_o = (state_q == STREAM) ? chunk_mask : '0;
`endif

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Randomised plus directed bench for vec_lane_sequencer against an element-level model.
// Three configurations (V/L = 20/4, 18/4, 3/3) share one stimulus stream.
module tb_vec_lane_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic [1:0]  op_type;
    logic [31:0] scalar;
    logic [31:0] e1 [0:19];
    logic [31:0] e2 [0:19];
    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    task tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task applyStimulus(input logic st, input logic [1:0] op, input logic [31:0] sc, input logic sl);
        start   = st;
        op_type = op;
        scalar  = sc;
        stall   = sl;
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_cfg
        localparam int VG  = (g == 0) ? 20 : ((g == 1) ? 18 : 3);
        localparam int LG  = (g == 2) ? 3 : 4;
        localparam int CG  = (VG + LG - 1) / LG;
        localparam int IWG = (CG > 1) ? $clog2(CG) : 1;

        logic [VG-1:0][31:0] rd1, rd2;
        logic                ready, valid, last, done;
        logic [LG-1:0][31:0] vec_a, vec_b;
        logic [IWG-1:0]      chunk_idx;
`ifdef VEC_SEQ_LANE_MASK_EN
        logic [LG-1:0]       mask;
`endif

        // Model: 0 idle, 1 streaming chunk k, 2 done pulse.
        int          mode = 0;
        int          k    = 0;
        logic [31:0] s1 [0:19];
        logic [31:0] s2 [0:19];
        logic [31:0] sc;
        logic [1:0]  op;

        always_comb begin
            for (int i = 0; i < VG; i++) begin
                rd1[i] = e1[i];
                rd2[i] = e2[i];
            end
        end

        vec_lane_sequencer #(.N(32), .V(VG), .L(LG)) dut (
            .CLK         (clk),
            .RST         (rst),
            .start_i     (start),
            .OpType      (op_type),
            .RD1_VEC_i   (rd1),
            .RD2_VEC_i   (rd2),
            .Scalar_i    (scalar),
            .stall_i     (stall),
            .ready_o     (ready),
            .valid_o     (valid),
            .Vec_A_o     (vec_a),
            .Vec_B_o     (vec_b),
            .chunk_idx_o (chunk_idx),
            .last_o      (last),
            .done_o      (done)
`ifdef VEC_SEQ_LANE_MASK_EN
            ,
            .mask_o      (mask)
`endif
        );

        always @(posedge clk) begin
            if (rst) begin
                mode <= 0;
                k    <= 0;
            end else begin
                case (mode)
                    0: if (start) begin
                        for (int i = 0; i < 20; i++) begin
                            s1[i] <= e1[i];
                            s2[i] <= e2[i];
                        end
                        sc   <= scalar;
                        op   <= op_type;
                        k    <= 0;
                        mode <= (op_type == 2'b00) ? 2 : 1;
                    end
                    1: if (!stall) begin
                        if (k == CG - 1) mode <= 2;
                        else k <= k + 1;
                    end
                    default: mode <= 0;
                endcase
            end
        end

        function automatic logic [31:0] lane_a(input int j);
            int e = k * LG + j;
            if (mode != 1 || e >= VG) return 32'd0;
            return (op == 2'b11) ? sc : s1[e];
        endfunction

        function automatic logic [31:0] lane_b(input int j);
            int e = k * LG + j;
            if (mode != 1 || e >= VG) return 32'd0;
            return (op == 2'b10) ? sc : s2[e];
        endfunction

        always @(negedge clk) begin
            if (chk_en) begin
                checkOutput($sformatf("g%0d ready", g), 64'(ready), 64'(mode == 0));
                checkOutput($sformatf("g%0d valid", g), 64'(valid), 64'(mode == 1));
                checkOutput($sformatf("g%0d done", g), 64'(done), 64'(mode == 2));
                checkOutput($sformatf("g%0d last", g), 64'(last), 64'(mode == 1 && k == CG - 1));
                if (mode == 1)
                    checkOutput($sformatf("g%0d idx", g), 64'(chunk_idx), 64'(k));
                for (int j = 0; j < LG; j++) begin
                    checkOutput($sformatf("g%0d lane%0d A", g, j), 64'(vec_a[j]), 64'(lane_a(j)));
                    checkOutput($sformatf("g%0d lane%0d B", g, j), 64'(vec_b[j]), 64'(lane_b(j)));
`ifdef VEC_SEQ_LANE_MASK_EN
                    checkOutput($sformatf("g%0d mask%0d", g, j), 64'(mask[j]),
                                64'(mode == 1 && (k * LG + j) < VG));
`endif
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            e1[i] = 32'(i);
            e2[i] = 32'(2 * i);
        end
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        checkOutput("reset ready", 64'(gen_cfg[0].ready), 64'd1);
        checkOutput("reset valid", 64'(gen_cfg[0].valid), 64'd0);
        checkOutput("reset idx", 64'(gen_cfg[0].chunk_idx), 64'd0);
        checkOutput("reset A0", 64'(gen_cfg[0].vec_a[0]), 64'd0);

        // Vector-vector, no stall.
        applyStimulus(1'b1, 2'b01, 32'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 2'b01, 32'd0, 1'b0);
        checkOutput("vv c0 valid", 64'(gen_cfg[0].valid), 64'd1);
        checkOutput("vv c0 ready", 64'(gen_cfg[0].ready), 64'd0);
        checkOutput("c1 last first", 64'(gen_cfg[2].last), 64'd1);
        tick(2);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("vv c2 A%0d", j), 64'(gen_cfg[0].vec_a[j]), 64'(8 + j));
            checkOutput($sformatf("vv c2 B%0d", j), 64'(gen_cfg[0].vec_b[j]), 64'(16 + 2 * j));
        end
        tick(2);
        checkOutput("vv c4 last", 64'(gen_cfg[0].last), 64'd1);
        tick(1);
        checkOutput("vv done", 64'(gen_cfg[0].done), 64'd1);
        checkOutput("vv done valid", 64'(gen_cfg[0].valid), 64'd0);
        tick(1);
        checkOutput("vv ready after", 64'(gen_cfg[0].ready), 64'd1);

        // Vector-scalar; scalar input changes after accept.
        applyStimulus(1'b1, 2'b10, 32'd3, 1'b0);
        tick(1);
        applyStimulus(1'b0, 2'b10, 32'd99, 1'b0);
        tick(1);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("vs c1 A%0d", j), 64'(gen_cfg[0].vec_a[j]), 64'(4 + j));
            checkOutput($sformatf("vs c1 B%0d", j), 64'(gen_cfg[0].vec_b[j]), 64'd3);
        end
        tick(4);
        checkOutput("vs done", 64'(gen_cfg[0].done), 64'd1);
        tick(1);

        // Scalar-vector; V=18 partial final chunk.
        applyStimulus(1'b1, 2'b11, 32'd7, 1'b0);
        tick(1);
        applyStimulus(1'b0, 2'b11, 32'd0, 1'b0);
        tick(4);
        checkOutput("sv18 A0", 64'(gen_cfg[1].vec_a[0]), 64'd7);
        checkOutput("sv18 A1", 64'(gen_cfg[1].vec_a[1]), 64'd7);
        checkOutput("sv18 A2", 64'(gen_cfg[1].vec_a[2]), 64'd0);
        checkOutput("sv18 B0", 64'(gen_cfg[1].vec_b[0]), 64'd32);
        checkOutput("sv18 B1", 64'(gen_cfg[1].vec_b[1]), 64'd34);
        checkOutput("sv18 B3", 64'(gen_cfg[1].vec_b[3]), 64'd0);
`ifdef VEC_SEQ_LANE_MASK_EN
        checkOutput("sv18 mask", 64'(gen_cfg[1].mask), 64'h3);
`endif
        tick(2);

        // Stall during chunk 1 while RD1 changes underneath.
        applyStimulus(1'b1, 2'b01, 32'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 2'b01, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) e1[i] = $urandom;
        tick(1);
        applyStimulus(1'b0, 2'b01, 32'd0, 1'b1);
        tick(3);
        checkOutput("stall idx held", 64'(gen_cfg[0].chunk_idx), 64'd1);
        checkOutput("stall A0 latched", 64'(gen_cfg[0].vec_a[0]), 64'd4);
        applyStimulus(1'b0, 2'b01, 32'd0, 1'b0);
        tick(4);
        checkOutput("stall done delayed", 64'(gen_cfg[0].done), 64'd1);
        tick(1);
        for (int i = 0; i < 20; i++) e1[i] = 32'(i);

        // Reset mid-stream aborts without a done pulse.
        applyStimulus(1'b1, 2'b01, 32'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 2'b01, 32'd0, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("abort valid", 64'(gen_cfg[0].valid), 64'd0);
        checkOutput("abort ready", 64'(gen_cfg[0].ready), 64'd1);
        checkOutput("abort done", 64'(gen_cfg[0].done), 64'd0);
        tick(1);
        checkOutput("abort no done", 64'(gen_cfg[0].done), 64'd0);
        applyStimulus(1'b1, 2'b01, 32'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 2'b01, 32'd0, 1'b0);
        checkOutput("restart idx", 64'(gen_cfg[0].chunk_idx), 64'd0);
        checkOutput("restart A1", 64'(gen_cfg[0].vec_a[1]), 64'd1);
        tick(5);
        checkOutput("restart done", 64'(gen_cfg[0].done), 64'd1);
        tick(1);

        // NOP with start held high through DONE.
        applyStimulus(1'b1, 2'b00, 32'd0, 1'b0);
        tick(1);
        checkOutput("nop done", 64'(gen_cfg[0].done), 64'd1);
        checkOutput("nop valid", 64'(gen_cfg[0].valid), 64'd0);
        checkOutput("nop not ready", 64'(gen_cfg[0].ready), 64'd0);
        tick(1);
        checkOutput("nop ready", 64'(gen_cfg[0].ready), 64'd1);
        tick(1);
        checkOutput("nop reaccept", 64'(gen_cfg[0].done), 64'd1);
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0);
        tick(2);

        // Randomised traffic with occasional data churn and resets.
        for (int it = 0; it < 600; it++) begin
            applyStimulus($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom,
                          $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 20; i++) begin
                    e1[i] = $urandom;
                    e2[i] = $urandom;
                end
            end
            rst = ($urandom_range(0, 80) == 0);
            tick(1);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'd0, 1'b0);
        tick(12);
        checkOutput("final idle", 64'(gen_cfg[0].ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
